// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO sequencer: single-cycle MULT/MULTU/MTHI/MTLO, divider handshake for DIV/DIVU
// Optional MULDIV_DIV0_EN: divide-by-zero is trapped locally and flagged on div0_o.
module muldiv_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [5:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   input  logic        ex_hold,
   output logic        stall_o,
   output logic        div_start_o,
   output logic        div_signed_o,
   output logic [31:0] div_a_o,
   output logic [31:0] div_b_o,
   output logic        div_annul_o,
   input  logic        div_ready_i,
   input  logic [63:0] div_result_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
`ifdef MULDIV_DIV0_EN
   ,
   output logic        div0_o
`endif
);

   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIV   = 6'b011010;
   localparam logic [5:0] OP_DIVU  = 6'b011011;
   localparam logic [5:0] OP_MTHI  = 6'b010001;
   localparam logic [5:0] OP_MTLO  = 6'b010011;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_n;
   logic        is_div;
   logic        retire;
   logic        div_go;
   logic [63:0] prod_s;
   logic [63:0] prod_u;

   assign is_div = (op == OP_DIV) || (op == OP_DIVU);
   assign retire = valid & ~flush & ~ex_hold;
   assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Divider launch deliberately ignores ex_hold so it overlaps the downstream stall.
`ifdef MULDIV_DIV0_EN
   assign div_go = (state == IDLE) & valid & ~flush & is_div & (b != 32'd0);
   assign div0_o = (state == IDLE) & retire & is_div & (b == 32'd0);
`else
   assign div_go = (state == IDLE) & valid & ~flush & is_div;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n     = state;
      stall_o     = 1'b0;
      div_start_o = 1'b0;
      div_annul_o = 1'b0;
      case (state)
         IDLE: begin
            stall_o = div_go;
            if (div_go) state_n = BUSY;
         end
         BUSY: begin
            stall_o     = 1'b1;
            div_start_o = ~flush;
            div_annul_o = flush;
            if (flush)            state_n = IDLE;
            else if (div_ready_i) state_n = DONE;
         end
         DONE: begin
            if (~ex_hold | flush) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_o         <= 32'd0;
         lo_o         <= 32'd0;
         div_a_o      <= 32'd0;
         div_b_o      <= 32'd0;
         div_signed_o <= 1'b0;
      end else if (state == IDLE) begin
         if (div_go) begin
            div_a_o      <= a;
            div_b_o      <= b;
            div_signed_o <= (op == OP_DIV);
         end
         if (retire) begin
            case (op)
               OP_MULT:  {hi_o, lo_o} <= prod_s;
               OP_MULTU: {hi_o, lo_o} <= prod_u;
               OP_MTHI:  hi_o <= a;
               OP_MTLO:  lo_o <= a;
               default: ;
            endcase
         end
      end else if (state == BUSY && div_ready_i && !flush) begin
         hi_o <= div_result_i[63:32];
         lo_o <= div_result_i[31:0];
      end
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle HI/LO sequencer for the EX stage. Decodes the EX-stage funct code, runs single-cycle MULT/MULTU, hands DIV/DIVU to the iterative divider over its start/ready/annul handshake, and owns the architectural HI/LO register pair. Stalls the pipeline while a division is in flight and annuls it on flush. Sits beside the ALU. The ALU keeps shifts, logic and add/sub; this block owns everything that touches HI/LO.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- valid  in  1  EX-stage instruction valid
- op  in  6  funct code: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011; all other codes are no-ops here
- a, b  in  32  rs/rt operands
- flush  in  1  exception/branch flush of the EX stage
- ex_hold  in  1  downstream stall; EX must not retire this cycle
- stall_o  out  1  request to freeze IF..EX
- div_start_o  out  1  divider start, held high until ready
- div_signed_o  out  1  1 for DIV, 0 for DIVU
- div_a_o, div_b_o  out  32  latched dividend/divisor
- div_annul_o  out  1  one-cycle cancel pulse
- div_ready_i  in  1  divider result valid, one-cycle pulse
- div_result_i  in  64  {remainder, quotient}
- hi_o, lo_o  out  32  architectural HI/LO
- div0_o  out  1  divide-by-zero flag; exists only with MULDIV_DIV0_EN

## Operation
- States: IDLE, BUSY, DONE. All are state-machine states; reset sets IDLE.
- Reset values: hi_o = lo_o = 0, stall_o = 0, div_start_o = 0, div_annul_o = 0, div_a_o = div_b_o = 0, div_signed_o = 0.
- Retire condition: valid & ~flush & ~ex_hold.

**IDLE**
- MULT retires: {hi,lo} <= signed 64-bit product of a, b.
- MULTU retires: {hi,lo} <= unsigned 64-bit product of a, b.
- MTHI retires: hi <= a. MTLO retires: lo <= a.
- valid & ~flush & DIV/DIVU:
  - latch a, b and signedness into div_a_o, div_b_o, div_signed_o;
  - go to BUSY.
  - This transition ignores ex_hold, so the divider overlaps the downstream stall.

**BUSY**
- div_start_o = 1.
- On div_ready_i:
  - hi <= div_result_i[63:32] (remainder);
  - lo <= div_result_i[31:0] (quotient);
  - go to DONE.
- On flush:
  - div_annul_o = 1 for one cycle;
  - div_start_o drops;
  - HI/LO are unchanged;
  - go to IDLE.
  - flush wins over a simultaneous div_ready_i.

**DONE**
- The held DIV instruction retires.
- Go to IDLE when ~ex_hold or flush. Otherwise stay in DONE.
- DONE never restarts the divider while the same DIV is still held in EX.

**stall_o**
- stall_o = (state==IDLE & valid & ~flush & op∈{DIV,DIVU}) | state==BUSY.

## Timing
- MULT, MULTU, MTHI, MTLO: zero stall; HI/LO update at the retiring edge, visible to MFHI/MFLO on the next cycle.
- DIV accepted at edge E:
  - stall_o is high combinationally in the cycle before E;
  - div_start_o is high from E until the edge after div_ready_i;
  - HI/LO update on the ready edge;
  - stall_o is low in DONE.
- Total stall = divider latency + 1 cycle.
- Back-to-back DIV: the second DIV enters EX only after DONE→IDLE and starts a fresh handshake.
- rst mid-division: state goes to IDLE immediately; no annul pulse; the divider is reset by the same rst.

## Configuration
- Macro: MULDIV_DIV0_EN.
- Defined:
  - DIV/DIVU with b == 0 never enters BUSY;
  - HI/LO are unchanged;
  - div0_o pulses high for the retiring cycle;
  - no stall.
- Undefined:
  - b == 0 goes to the divider like any other value;
  - the div0_o port is absent.

## Test plan
- MULT a=FFFFFFFE, b=00000003 → hi=FFFFFFFF, lo=FFFFFFFA next cycle, stall_o never high.
- MULTU a=FFFFFFFF, b=00000002 → hi=00000001, lo=FFFFFFFE. Then MTHI a=12345678 → hi=12345678, lo unchanged.
- DIV a=FFFFFFF9 (−7), b=00000002 → div_signed_o=1, stall for divider latency + 1, then lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV, then flush in cycle 5 of BUSY → one div_annul_o pulse, state IDLE, HI/LO keep the prior values. Also flush coinciding with div_ready_i → HI/LO not written.
- DIV completes while ex_hold=1 for 3 cycles → state stays in DONE, div_start_o stays 0 and no restart occurs, HI/LO written once. Also rst asserted in BUSY → all outputs reach reset values asynchronously.
- With MULTI: MULDIV_DIV0_EN defined, DIV a=5, b=0 → div0_o=1 for one cycle, no stall, HI/LO unchanged. Without the macro → the divider is started.
